instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//   Sequences the combinational instruction memory: owns the PC register, drives the word
//   address, and buffers fetched words in a small FIFO towards decode (valid/ready).
//   Handles branch/jump redirects by flushing the buffer, and raises a sticky fault on
//   out-of-range fetches. Sits between the instruction memory and the decode stage.
// PARAMETERS
//   RESET_PC   32'h0000_0000  byte address of the first fetch after reset
//   MEM_WORDS  30             number of 32-bit words in instruction memory (valid index 0..MEM_WORDS-1)
//   FIFO_DEPTH 2              fetch buffer entries (power of 2, >=2)
// PORTS
//   clk            in   1   clock, all state updates on rising edge
//   rst            in   1   reset, synchronous, active-high
//   en             in   1   fetch enable; 0 = no new fetches, buffer still drains
//   mem_addr       out  32  word index to instruction memory = pc_q >> 2
//   mem_rdata      in   32  instruction word, valid combinationally in the same cycle
//   redirect_valid in   1   flush and restart fetch at redirect_pc
//   redirect_pc    in   32  new byte PC; bits [1:0] ignored (forced to 0)
//   out_valid      out  1   buffer head valid (registered)
//   out_ready      in   1   decode accepts head when out_valid & out_ready
//   out_instr      out  32  instruction at buffer head
//   out_pc         out  32  byte PC of out_instr
//   fault          out  1   sticky: fetch attempted at word index >= MEM_WORDS
//   pc_q           out  32  next byte PC to fetch
// BEHAVIOUR
//   Reset (rst=1 at edge): pc_q=RESET_PC, state=IDLE, count=0, out_valid=0, out_instr=0,
//     out_pc=0, fault=0. Reset mid-operation discards buffered entries, no partial state.
//   States: IDLE -> FETCH when en=1 (no fetch in transition cycle); FETCH -> FAULT when
//     pc_q>>2 >= MEM_WORDS; FAULT holds until redirect_valid or rst. IDLE also left via redirect.
//   Priority per cycle: rst > redirect_valid > fault check > en/push.
//   pop  = out_valid & out_ready.
//   push = state==FETCH & en & (pc_q>>2 < MEM_WORDS) & (count<FIFO_DEPTH | pop) & ~redirect_valid.
//   On push: entry {mem_rdata, pc_q} written at tail; pc_q <= pc_q+4 (32-bit wrap).
//   Simultaneous push & pop when full: allowed, count unchanged.
//   Latency: en seen in IDLE at cycle N -> first push N+1 -> out_valid=1 at N+2.
//   Steady state with out_ready=1: one instruction per cycle.
//   out_valid = (count!=0), out_instr/out_pc from head entry; stable while out_valid & ~out_ready.
//   Redirect: count<=0, out_valid<=0 next cycle, pc_q<={redirect_pc[31:2],2'b00}, fault<=0,
//     state<=FETCH; no push and no pop counted in redirect cycle; first new word valid 2 cycles later.
//   Fault: entering FAULT sets fault=1; no pushes; already-buffered entries still drain; pc_q frozen.
//   Out-of-range index never drives mem_rdata into buffer; mem_addr still equals pc_q>>2.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds ports perf_fetch_cnt out 32 (number of pushes) and
//     perf_stall_cnt out 32 (cycles in FETCH with en=1, in range, buffer full, no pop).
//     Both reset to 0 on rst only (not on redirect), wrap modulo 2^32.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   Mem words 0..3 = 0x11,0x22,0x33,0x44; rst then en=1, out_ready=1 -> out_valid at
//     cycle 2, outputs (0x11,pc 0),(0x22,4),(0x33,8),(0x44,12) on consecutive cycles.
//   out_ready=0 for 5 cycles after first fetch -> count reaches 2, pc_q stops at 8, out_instr
//     holds 0x11; release -> 0x11,0x22,0x33 with no gap or duplicate; stall_cnt=3 (if enabled).
//   Redirect to 0x0000_000E while buffer full -> out_valid=0 next cycle, pc_q=0x0C,
//     next outputs (mem[3],0x0C),(mem[4],0x10).
//   Redirect to 4*(MEM_WORDS-1) -> one valid word at pc 0x74, then fault=1, no further
//     pushes; later redirect to 0 clears fault and resumes at mem[0].
//   rst asserted with 2 buffered entries and redirect_valid=1 same cycle -> next cycle
//     out_valid=0, pc_q=RESET_PC, state IDLE, fault=0, perf counters 0.
//   en toggled 1,0,1 each cycle with out_ready=1 -> pushes only on en=1 cycles, pc increments
//     by 4 per push, no lost or repeated PCs.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the PC, addresses the combinational instruction memory and
// buffers fetched words toward decode. Optional perf counters via `define FETCH_PERF_CNT_EN.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_WORDS  = 30,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [31:0] pc_q
);

    localparam int          PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C     = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] MEM_WORDS_C = 32'(MEM_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          fault_q, fault_d;
    logic [31:0]   instr_buf_q [FIFO_DEPTH];
    logic [31:0]   pc_buf_q    [FIFO_DEPTH];
    logic          in_range, full, pop, push;

    assign mem_addr = {2'b00, pc_q[31:2]};
    assign in_range = (mem_addr < MEM_WORDS_C);
    assign full     = (count_q == DEPTH_C);
    // A redirect flushes the buffer, so a head handshake in that cycle is not a pop.
    assign pop      = out_valid & out_ready & ~redirect_valid;
    assign push     = (state_q == S_FETCH) & en & in_range & (~full | pop) & ~redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
            pc_d    = redirect_pc & ~32'h3;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (en) state_d = S_FETCH;
                S_FETCH: if (!in_range) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end
                default: ;
            endcase
            if (push) begin
                tail_d = tail_q + PW'(1);
                pc_d   = pc_q + 32'd4;
            end
            if (pop) head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fault_q <= fault_d;
        end
    end

    // Buffer storage is data-only; outputs are masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_buf_q[tail_q] <= mem_rdata;
            pc_buf_q[tail_q]    <= pc_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_buf_q[head_q] : 32'd0;
    assign out_pc    = out_valid ? pc_buf_q[head_q]    : 32'd0;
    assign fault     = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        stall;

    assign stall = (state_q == S_FETCH) & en & in_range & full & ~pop & ~redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
